// File: rtl/uart_frame_arbiter_if.sv
// Word-source and uart_tx side signals of uart_frame_arbiter.
// Handshakes: a source raises req_valid with stable req_data and holds both until the
// one-cycle req_ready pulse; the word is taken on the edge that ends the req_ready cycle.
interface uart_frame_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  uart_tx_en;
    logic [7:0]            uart_tx_data;
    logic                  uart_tx_busy;
    logic                  frame_active;
    logic [1:0]            grant_id;

    modport master (
        input  req_valid, req_data, uart_tx_busy,
        output req_ready, uart_tx_en, uart_tx_data, frame_active, grant_id
    );

    modport slave (
        output req_valid, req_data, uart_tx_busy,
        input  req_ready, uart_tx_en, uart_tx_data, frame_active, grant_id
    );
endinterface

// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that serialises 32-bit words from up to four sources into
// 7-byte frames (sync, header, 4 data bytes, checksum) for a shared uart_tx.
module uart_frame_arbiter #(
    parameter int          NUM_REQ   = 2,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_frame_arbiter_if.master arb_if,
    output logic [1:0]           state_o
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [5:0]  seq_q, seq_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [1:0]  grant_q, grant_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  hdr_q, hdr_d;
    logic [7:0]  tx_data_q, tx_data_d;

    logic [3:0]   valid4;
    logic [127:0] word4;
    logic [2:0]   cand3;
    logic         found;
    logic [1:0]   winner;
    logic [31:0]  word_sel;
    logic         accept;
    logic [3:0]   ready4;
    logic [7:0]   checksum;
    logic [7:0]   next_byte;

    // Search order starts one past the last accepted source, wrapping at NUM_REQ.
    always_comb begin
        valid4 = '0;
        valid4[NUM_REQ-1:0] = arb_if.req_valid;
        found  = 1'b0;
        winner = last_grant_q;
        cand3  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand3 = {1'b0, last_grant_q} + 3'(k);
            if (cand3 >= 3'(NUM_REQ)) cand3 = cand3 - 3'(NUM_REQ);
            if (!found && valid4[cand3[1:0]]) begin
                found  = 1'b1;
                winner = cand3[1:0];
            end
        end
    end

    always_comb begin
        word4 = '0;
        word4[32*NUM_REQ-1:0] = arb_if.req_data;
        word_sel = word4[{winner, 5'b0} +: 32];
    end

    // rst_n gates the combinational pulse so req_ready reads 0 while reset is held.
    assign accept = rst_n && (state_q == ST_IDLE) && found;
    assign ready4 = 4'b0001 << winner;

    assign checksum = hdr_q ^ word_q[7:0] ^ word_q[15:8] ^ word_q[23:16] ^ word_q[31:24];

    always_comb begin
        case (idx_q + 3'd1)
            3'd1:    next_byte = hdr_q;
            3'd2:    next_byte = word_q[7:0];
            3'd3:    next_byte = word_q[15:8];
            3'd4:    next_byte = word_q[23:16];
            3'd5:    next_byte = word_q[31:24];
            3'd6:    next_byte = checksum;
            default: next_byte = SYNC_BYTE;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        seq_d        = seq_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        word_d       = word_q;
        hdr_d        = hdr_q;
        tx_data_d    = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d      = ST_SEND;
                    idx_d        = 3'd0;
                    word_d       = word_sel;
                    grant_d      = winner;
                    last_grant_d = winner;
                    hdr_d        = {winner, seq_q};
                    tx_data_d    = SYNC_BYTE;
                end
            end
            ST_SEND:  state_d = ST_GUARD;
            ST_GUARD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!arb_if.uart_tx_busy) begin
                    if (idx_q == 3'd6) begin
                        state_d = ST_IDLE;
                        idx_d   = 3'd0;
                        seq_d   = seq_q + 6'd1;
                    end else begin
                        state_d   = ST_SEND;
                        idx_d     = idx_q + 3'd1;
                        tx_data_d = next_byte;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= 3'd0;
            seq_q        <= 6'd0;
            last_grant_q <= 2'(NUM_REQ - 1);
            grant_q      <= 2'd0;
            word_q       <= 32'd0;
            hdr_q        <= 8'd0;
            tx_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            seq_q        <= seq_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            word_q       <= word_d;
            hdr_q        <= hdr_d;
            tx_data_q    <= tx_data_d;
        end
    end

    assign arb_if.req_ready    = ready4[NUM_REQ-1:0] & {NUM_REQ{accept}};
    assign arb_if.uart_tx_en   = (state_q == ST_SEND);
    assign arb_if.uart_tx_data = tx_data_q;
    assign arb_if.frame_active = accept || (state_q != ST_IDLE);
    assign arb_if.grant_id     = grant_q;
    assign state_o             = state_q;
endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench for uart_frame_arbiter with NUM_REQ=2 and a counting busy model.
module tb_uart_frame_arbiter;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;

  uart_frame_arbiter_if #(.NUM_REQ(2)) bus ();

  uart_frame_arbiter #(.NUM_REQ(2), .SYNC_BYTE(8'hA5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .arb_if  (bus.master),
    .state_o (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  int cyc = 0;
  int last_strobe_cyc = 0;
  int strobe_cnt = 0;
  int busy_len = 0;
  int busy_cnt = 0;
  int ready0_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [1:0] id, input logic [5:0] seq, input logic [31:0] w);
    logic [7:0] hdr;
    hdr = {id, seq};
    exp_q.push_back(8'hA5);
    exp_q.push_back(hdr);
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(hdr ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]);
  endtask

  task automatic push7(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2); exp_q.push_back(b3);
    exp_q.push_back(b4); exp_q.push_back(b5); exp_q.push_back(b6);
  endtask

  // Monitor + busy model + scoreboard, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (state_dbg == ST_IDLE) strobe_cnt = 0;
    if (bus.uart_tx_en) begin
      check("strobe_not_while_busy", {31'd0, bus.uart_tx_busy}, 32'd0);
      check("strobe_in_send", {30'd0, state_dbg}, {30'd0, ST_SEND});
      if (strobe_cnt > 0)
        check("strobe_gap", cyc - last_strobe_cyc, (busy_len == 0) ? 3 : busy_len + 1);
      check("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("tx_byte", {24'd0, bus.uart_tx_data}, {24'd0, exp_q.pop_front()});
      last_strobe_cyc = cyc;
      strobe_cnt++;
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    bus.uart_tx_busy = (busy_cnt != 0);
    if (bus.req_ready != 2'b00) begin
      check("ready_only_in_idle", {30'd0, state_dbg}, {30'd0, ST_IDLE});
      check("ready_onehot", $countones(bus.req_ready), 1);
    end
    if (bus.req_ready[0]) ready0_cnt++;
  end

  // driver tasks
  task automatic wait_grant(input int budget, output int who);
    int n;
    who = -1;
    n = 0;
    #1;
    while (bus.req_ready == 2'b00 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_ready == 2'b01) who = 0;
    else if (bus.req_ready == 2'b10) who = 1;
    check("grant_seen", {31'd0, who >= 0}, 32'd1);
    if (who >= 0) begin
      check("frame_active_at_grant", {31'd0, bus.frame_active}, 32'd1);
      @(posedge clk);
      #1;
      bus.req_valid[who] = 1'b0;
      check("grant_id_after_capture", {30'd0, bus.grant_id}, who);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && state_dbg == ST_IDLE) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("frame_done", {31'd0, exp_q.size() == 0 && state_dbg == ST_IDLE}, 32'd1);
  endtask

  task automatic wait_exp_size(input int sz, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != sz && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("progress_reached", exp_q.size(), sz);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int who;
    int n;
    logic [31:0] w;
    bus.req_valid = 2'b00;
    bus.req_data = '0;
    bus.uart_tx_busy = 1'b0;

    // Reset state while rst_n is held low.
    #12;
    check("rst_tx_en", {31'd0, bus.uart_tx_en}, 32'd0);
    check("rst_tx_data", {24'd0, bus.uart_tx_data}, 32'h00);
    check("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
    check("rst_frame_active", {31'd0, bus.frame_active}, 32'd0);
    check("rst_grant_id", {30'd0, bus.grant_id}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1: requester 0 alone, no busy.
    push7(8'hA5, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08);
    bus.req_data[31:0] = 32'h12345678;
    bus.req_valid[0] = 1'b1;
    wait_grant(20, who);
    check("f1_winner", who, 0);
    @(negedge clk);
    check("f1_sync_latency_en", {31'd0, bus.uart_tx_en}, 32'd1);
    check("f1_sync_latency_data", {24'd0, bus.uart_tx_data}, 32'hA5);
    wait_done(100);
    check("f1_ready0_pulses", ready0_cnt, 1);
    check("f1_frame_active_low", {31'd0, bus.frame_active}, 32'd0);
    @(negedge clk);

    // Both requesters valid, 20-cycle busy after each strobe.
    busy_len = 20;
    push7(8'hA5, 8'h41, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h63);
    push7(8'hA5, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'h0A);
    bus.req_data = {32'hDEADBEEF, 32'h12345678};
    bus.req_valid = 2'b11;
    wait_grant(20, who);
    check("rr_first_winner", who, 1);
    wait_grant(400, who);
    check("rr_second_winner", who, 0);
    wait_done(400);
    busy_len = 0;
    repeat (3) @(negedge clk);

    // req1 raised mid-frame: must wait for the first IDLE cycle.
    push_frame(2'd0, 6'd3, 32'hCAFEF00D);
    push_frame(2'd1, 6'd4, 32'h0F1E2D3C);
    bus.req_data[31:0] = 32'hCAFEF00D;
    bus.req_valid[0] = 1'b1;
    wait_grant(20, who);
    check("mid_first_winner", who, 0);
    wait_exp_size(12, 50);
    bus.req_data[63:32] = 32'h0F1E2D3C;
    bus.req_valid[1] = 1'b1;
    n = 0;
    while (state_dbg != ST_IDLE && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_ready_first_idle", {30'd0, bus.req_ready}, 32'b10);
    wait_grant(5, who);
    check("mid_second_winner", who, 1);
    wait_done(100);
    @(negedge clk);

    // Reset in the middle of a frame from requester 1.
    push_frame(2'd1, 6'd5, 32'h11223344);
    bus.req_data[63:32] = 32'h11223344;
    bus.req_valid[1] = 1'b1;
    wait_grant(20, who);
    check("rstmid_winner", who, 1);
    wait_exp_size(2, 50);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_tx_en", {31'd0, bus.uart_tx_en}, 32'd0);
    check("rstmid_tx_data", {24'd0, bus.uart_tx_data}, 32'h00);
    check("rstmid_req_ready", {30'd0, bus.req_ready}, 32'd0);
    check("rstmid_frame_active", {31'd0, bus.frame_active}, 32'd0);
    check("rstmid_grant_id", {30'd0, bus.grant_id}, 32'd0);
    check("rstmid_state", {30'd0, state_dbg}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rstmid_no_strobes_after", {31'd0, bus.uart_tx_en}, 32'd0);

    // First frame after reset restarts at seq 0, then 64 more frames wrap seq to 0.
    for (int i = 0; i <= 64; i++) begin
      w = (i == 0) ? 32'h55AA55AA : $urandom;
      push_frame(2'd0, 6'(i), w);
      bus.req_data[31:0] = w;
      bus.req_valid[0] = 1'b1;
      wait_grant(20, who);
      check("seq_run_winner", who, 0);
      wait_done(100);
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
